// File: rtl/dickson_btn_reader_if.sv
// Slot bus between the CPU-side master and an MMIO I/O core.
`timescale 1ns/1ps
interface dickson_btn_reader_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs,
        output read,
        output write,
        output addr,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  cs,
        input  read,
        input  write,
        input  addr,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/dickson_btn_reader.sv
// Button/switch reader slot: 2-flop sync, programmable per-bit debounce,
// sticky W1C rise/fall edge flags.
`timescale 1ns/1ps
module dickson_btn_reader #(
    parameter int unsigned W          = 4,
    parameter int unsigned DB_DEFAULT = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    dickson_btn_reader_if.slave   bus,
    input  logic [W-1:0]          btn_in
);

    localparam int unsigned CW = 16;
    localparam logic [4:0] A_LEVEL = 5'd0;
    localparam logic [4:0] A_RISE  = 5'd1;
    localparam logic [4:0] A_FALL  = 5'd2;
    localparam logic [4:0] A_LIMIT = 5'd3;

    logic [W-1:0]  sync1_q, sync2_q;
    logic [W-1:0]  db_q, db_d;
    logic [W-1:0]  rise_q, rise_d, fall_q, fall_d;
    logic [W-1:0]  rise_set, fall_set;
    logic [CW-1:0] cnt_q [W];
    logic [CW-1:0] cnt_d [W];
    logic [CW-1:0] limit_q, limit_d;
    logic [CW-1:0] lim_m1;
    logic          wr_en;
    logic          unused_bits;

    assign wr_en       = bus.cs & bus.write;
    assign unused_bits = ^{bus.read, bus.wr_data[31:CW]};

    // LIMIT of 0 behaves as 1, so the terminal count is 0 in both cases.
    always_comb begin
        lim_m1 = '0;
        if (limit_q != '0) begin
            lim_m1 = limit_q - CW'(1);
        end
    end

    // Per-bit debounce; >= keeps a shrunk LIMIT from letting cnt run past it.
    always_comb begin
        db_d     = db_q;
        rise_set = '0;
        fall_set = '0;
        for (int i = 0; i < int'(W); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] >= lim_m1) begin
                    db_d[i]     = sync2_q[i];
                    rise_set[i] = sync2_q[i];
                    fall_set[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Register writes; an edge landing with a W1C clear keeps the flag set.
    always_comb begin
        rise_d  = rise_q;
        fall_d  = fall_q;
        limit_d = limit_q;
        if (wr_en && bus.addr == A_RISE) begin
            rise_d = rise_q & ~bus.wr_data[W-1:0];
        end
        if (wr_en && bus.addr == A_FALL) begin
            fall_d = fall_q & ~bus.wr_data[W-1:0];
        end
        if (wr_en && bus.addr == A_LIMIT) begin
            limit_d = bus.wr_data[CW-1:0];
        end
        rise_d = rise_d | rise_set;
        fall_d = fall_d | fall_set;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            limit_q <= CW'(DB_DEFAULT);
            for (int i = 0; i < int'(W); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            limit_q <= limit_d;
            for (int i = 0; i < int'(W); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read mux is purely address-decoded; reads have no side effects.
    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            A_LEVEL: bus.rd_data = 32'(db_q);
            A_RISE:  bus.rd_data = 32'(rise_q);
            A_FALL:  bus.rd_data = 32'(fall_q);
            A_LIMIT: bus.rd_data = 32'(limit_q);
            default: bus.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_dickson_btn_reader.sv
// Directed bench for dickson_btn_reader: reset defaults, debounce timing,
// glitch rejection, W1C flags, set/clear collision and LIMIT boundaries.
`timescale 1ns/1ps
module tb_dickson_btn_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn;
    logic [31:0] d;
    int          checks   = 0;
    int          failures = 0;

    dickson_btn_reader_if bus_if ();

    dickson_btn_reader #(.W(4), .DB_DEFAULT(50000)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_if),
        .btn_in (btn)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        bus_if.cs      = 1'b1;
        bus_if.write   = 1'b1;
        bus_if.addr    = a;
        bus_if.wr_data = v;
        @(posedge clk);
        #1;
        bus_if.cs      = 1'b0;
        bus_if.write   = 1'b0;
        bus_if.wr_data = '0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        bus_if.addr = a;
        #1;
        v = bus_if.rd_data;
    endtask

    task automatic init(input logic [15:0] lim);
        reset = 1'b0;
        btn   = 4'h0;
        step(2);
        reset = 1'b1;
        wr(5'd3, 32'(lim));
    endtask

    task automatic test_reset;
        reset = 1'b0;
        btn   = 4'hF;
        step(2);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_level got=%h exp=%h", d, 32'h0); end
        rd(5'd1, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_rise got=%h exp=%h", d, 32'h0); end
        rd(5'd2, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_fall got=%h exp=%h", d, 32'h0); end
        rd(5'd3, d); checks++;
        if (d !== 32'd50000) begin failures++; $display("FAIL reset_limit got=%0d exp=%0d", d, 50000); end
        reset = 1'b1;
        step(50001);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL default_db_early got=%h exp=%h", d, 32'h0); end
        step(1);
        rd(5'd0, d); checks++;
        if (d !== 32'hF) begin failures++; $display("FAIL default_db_update got=%h exp=%h", d, 32'hF); end
        rd(5'd1, d); checks++;
        if (d !== 32'hF) begin failures++; $display("FAIL default_rise got=%h exp=%h", d, 32'hF); end
    endtask

    task automatic test_clean_press;
        init(16'd4);
        btn = 4'h1;
        step(5);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL press_early got=%h exp=%h", d, 32'h0); end
        step(1);
        rd(5'd0, d); checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL press_level got=%h exp=%h", d, 32'h1); end
        rd(5'd1, d); checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL press_rise got=%h exp=%h", d, 32'h1); end
        btn = 4'h0;
        step(5);
        rd(5'd0, d); checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL release_early got=%h exp=%h", d, 32'h1); end
        step(1);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL release_level got=%h exp=%h", d, 32'h0); end
        rd(5'd2, d); checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL release_fall got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_glitch;
        init(16'd4);
        btn = 4'h4;
        step(3);
        btn = 4'h0;
        step(10);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL glitch_level got=%h exp=%h", d, 32'h0); end
        rd(5'd1, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL glitch_rise got=%h exp=%h", d, 32'h0); end
        rd(5'd2, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL glitch_fall got=%h exp=%h", d, 32'h0); end
        btn = 4'h4;
        step(4);
        btn = 4'h0;
        step(1);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL pulse4_early got=%h exp=%h", d, 32'h0); end
        step(1);
        rd(5'd0, d); checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL pulse4_level got=%h exp=%h", d, 32'h4); end
        rd(5'd1, d); checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL pulse4_rise got=%h exp=%h", d, 32'h4); end
        step(10);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL pulse4_fall_level got=%h exp=%h", d, 32'h0); end
        rd(5'd2, d); checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL pulse4_fall got=%h exp=%h", d, 32'h4); end
    endtask

    task automatic test_w1c;
        init(16'd4);
        btn = 4'hB;
        step(8);
        rd(5'd1, d); checks++;
        if (d !== 32'hB) begin failures++; $display("FAIL w1c_setup got=%h exp=%h", d, 32'hB); end
        wr(5'd1, 32'h2);
        rd(5'd1, d); checks++;
        if (d !== 32'h9) begin failures++; $display("FAIL w1c_clear_bit1 got=%h exp=%h", d, 32'h9); end
        wr(5'd1, 32'h0);
        rd(5'd1, d); checks++;
        if (d !== 32'h9) begin failures++; $display("FAIL w1c_zero got=%h exp=%h", d, 32'h9); end
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, d); checks++;
        if (d !== 32'hB) begin failures++; $display("FAIL level_ro got=%h exp=%h", d, 32'hB); end
        bus_if.cs      = 1'b0;
        bus_if.write   = 1'b1;
        bus_if.addr    = 5'd3;
        bus_if.wr_data = 32'h7;
        step(1);
        bus_if.write   = 1'b0;
        rd(5'd3, d); checks++;
        if (d !== 32'd4) begin failures++; $display("FAIL write_no_cs got=%0d exp=%0d", d, 4); end
        wr(5'd1, 32'hF);
        rd(5'd1, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL w1c_all got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_collision;
        init(16'd4);
        btn = 4'h2;
        step(5);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL coll_pre got=%h exp=%h", d, 32'h0); end
        wr(5'd1, 32'h2);
        rd(5'd1, d); checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL coll_set_wins got=%h exp=%h", d, 32'h2); end
        rd(5'd0, d); checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL coll_level got=%h exp=%h", d, 32'h2); end
        wr(5'd1, 32'h2);
        rd(5'd1, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL coll_later_clear got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_boundaries;
        init(16'd0);
        rd(5'd3, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL lim0_read got=%h exp=%h", d, 32'h0); end
        btn = 4'h8;
        step(2);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL lim0_early got=%h exp=%h", d, 32'h0); end
        step(1);
        rd(5'd0, d); checks++;
        if (d !== 32'h8) begin failures++; $display("FAIL lim0_rise got=%h exp=%h", d, 32'h8); end
        btn = 4'h0;
        step(2);
        rd(5'd0, d); checks++;
        if (d !== 32'h8) begin failures++; $display("FAIL lim0_hold got=%h exp=%h", d, 32'h8); end
        step(1);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL lim0_fall got=%h exp=%h", d, 32'h0); end
        wr(5'd3, 32'd100);
        btn = 4'h1;
        step(61);
        wr(5'd3, 32'd10);
        rd(5'd0, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL shrink_early got=%h exp=%h", d, 32'h0); end
        step(1);
        rd(5'd0, d); checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL shrink_no_wrap got=%h exp=%h", d, 32'h1); end
        wr(5'd3, 32'hFFFF_0007);
        rd(5'd3, d); checks++;
        if (d !== 32'h7) begin failures++; $display("FAIL limit_upper got=%h exp=%h", d, 32'h7); end
        rd(5'd5, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL addr5 got=%h exp=%h", d, 32'h0); end
        rd(5'd31, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL addr31 got=%h exp=%h", d, 32'h0); end
    endtask

    initial begin
        reset          = 1'b0;
        btn            = 4'h0;
        bus_if.cs      = 1'b0;
        bus_if.read    = 1'b0;
        bus_if.write   = 1'b0;
        bus_if.addr    = '0;
        bus_if.wr_data = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_w1c();
        test_collision();
        test_boundaries();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dickson_btn_reader.md
Name: dickson_btn_reader

Overview:
- MMIO slot core in the opposite direction to the LED blinker: samples W external switch/button inputs instead of driving outputs.
- Synchronizes each input, debounces it with a CPU-programmable interval, and latches rising and falling edges into sticky write-1-to-clear registers.
- Sits on the same slot bus as other I/O cores; the CPU reads the debounced level and the edge flags.

Parameters:
- W, 4, number of button/switch inputs (1..16).
- DB_DEFAULT, 50000, reset value of the debounce limit register, in clk cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk edge).
- cs  input  1  slot chip select.
- read  input  1  slot read strobe; reads have no side effects.
- write  input  1  slot write strobe.
- addr  input  5  register address within the slot.
- wr_data  input  32  write data.
- rd_data  output  32  read data, combinational from addr.
- btn_in  input  W  raw asynchronous external inputs.

Behaviour:
- Register map (word addresses):
  - 0 LEVEL: RO, db[W-1:0].
  - 1 RISE: sticky flags, W1C.
  - 2 FALL: sticky flags, W1C.
  - 3 LIMIT: RW, 16 bits; upper bits read 0.
  - Other addresses read 0; writes to them are ignored. Writes to addr 0 are ignored.
- rd_data = zero-extended register selected by addr, independent of cs/read; unused upper bits read 0.
- Writes occur only on a clk edge with cs=1 and write=1.
- Reset (reset=0 at clk edge):
  - sync1, sync2, db, RISE, FALL and all counters go to 0.
  - LIMIT goes to DB_DEFAULT.
  - Reset mid-debounce discards partial counts.
- Synchronizer: 2-flop per bit. btn_in → sync1 → sync2.
- Debounce, per bit i:
  - N = LIMIT, with LIMIT=0 treated as 1. cnt[i] is 16 bits.
  - If sync2[i]==db[i]: cnt[i] <= 0.
  - Else if cnt[i] == N-1: db[i] <= sync2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Result: db follows sync2 only after N consecutive mismatching cycles. Any glitch shorter than N cycles resets the count and is ignored.
- Latency: btn_in stable from before edge k → sync2 valid after edge k+1 → db updates on edge k+1+N. Level readable from that edge.
- LIMIT write mid-count: new N applies from the next cycle. If cnt[i] >= new N-1 while still mismatching, the next mismatch cycle must not wrap. Compare with cnt >= N-1 so db updates on that cycle.
- Edge capture, on the same edge db[i] updates:
  - 0→1 sets RISE[i].
  - 1→0 sets FALL[i].
  - Flags stay set until cleared.
- W1C: a write to addr 1/2 clears flag bits where wr_data[i]=1; bits with wr_data[i]=0 are unchanged.
- Simultaneous set and clear of the same bit in one cycle: set wins (flag = 1).
- At most one db transition per bit per cycle, so RISE and FALL never set together for the same bit.

Test Plan:
- Reset and defaults: hold reset=0 for 2 cycles with btn_in=4'hF → addr0=0, addr1=0, addr2=0, addr3=50000. Release reset → db stays 0 until 50000 stable cycles have elapsed.
- Clean press: write LIMIT=4; btn_in[0] 0→1 before edge k → LEVEL=4'h1 after edge k+5 (not before) and RISE=4'h1. Release → LEVEL=0 and FALL=4'h1 after 5 further edges.
- Glitch rejection: LIMIT=4; pulse btn_in[2] high for 3 cycles, then low → LEVEL, RISE and FALL remain 0. A 4-cycle pulse → LEVEL[2]=1 after 5 edges and RISE[2]=1.
- W1C: RISE=4'hB; write addr1 wr_data=4'h2 → RISE=4'h9. Write 0 → unchanged. Write addr0 → LEVEL unaffected.
- Set/clear collision: schedule a W1C write of bit1 on the same edge db[1] rises → RISE[1]=1 afterwards.
- Boundaries: LIMIT=0 → db follows sync2 one cycle after it changes. LIMIT=100 written while cnt=60, then LIMIT=10 → db updates on the next mismatch cycle with no wrap. Read addr 5 → 0.
